// File: rtl/rvsteel_spi_peripheral.sv
// Memory-mapped SPI target for the Steel IO bus (SPI modes 0-3, one byte per transfer).
// Define RVSTEEL_SPI_PERIPHERAL_IRQ_EN to add the irq output and the IRQ_EN register.
//
// state      | meaning
// DESELECTED | cs high, bit counter held at zero, sclk edges ignored
// SELECTED   | cs low, poci driven from tx_shift, bytes shifted in/out

module rvsteel_spi_peripheral #(
    parameter logic [31:0] BASE_ADDRESS = 32'h80040000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rw_address,
    output logic [31:0] read_data,
    input  logic        read_request,
    output logic        read_response,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    input  logic        write_request,
    output logic        write_response,
    input  logic        sclk,
    input  logic        pico,
    input  logic        cs,
`ifdef RVSTEEL_SPI_PERIPHERAL_IRQ_EN
    output logic        irq,
`endif
    output logic        poci
);

    localparam logic [31:0] ADDR_CPOL   = BASE_ADDRESS + 32'h00;
    localparam logic [31:0] ADDR_CPHA   = BASE_ADDRESS + 32'h04;
    localparam logic [31:0] ADDR_TXDATA = BASE_ADDRESS + 32'h08;
    localparam logic [31:0] ADDR_RXDATA = BASE_ADDRESS + 32'h0C;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDRESS + 32'h10;
`ifdef RVSTEEL_SPI_PERIPHERAL_IRQ_EN
    localparam logic [31:0] ADDR_IRQ_EN = BASE_ADDRESS + 32'h14;
`endif
    localparam logic [31:0] NO_DATA = 32'hdeadbeef;

    typedef enum logic {
        DESELECTED = 1'b0,
        SELECTED   = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        cpol;
    logic        cpha;
    logic [7:0]  tx_buf;
    logic        tx_full;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_buf;
    logic        rx_valid;
    logic        rx_overrun;
    logic [7:0]  rx_shift;
    logic [2:0]  bit_cnt;
`ifdef RVSTEEL_SPI_PERIPHERAL_IRQ_EN
    logic [1:0]  irq_en;
`endif

    logic [2:0]  sclk_s;
    logic [1:0]  cs_s;
    logic [1:0]  pico_s;

    logic        cs_sync;
    logic        pico_sync;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        lead_edge;
    logic        trail_edge;
    logic        sample_edge;
    logic        shift_edge;

    logic        start;
    logic        do_sample;
    logic        do_shift;
    logic        byte_done;
    logic        reload;
    logic        tx_step;
    logic        tx_consume;
    logic [7:0]  tx_load_val;
    logic [7:0]  rx_byte;
    logic        busy;

    logic        write_ok;
    logic        wr_cpol;
    logic        wr_cpha;
    logic        wr_txdata;
    logic        wr_status;
    logic        rd_rx;

    // Input synchronizers; sclk keeps a third flop so edges are detected on settled values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_s <= 3'b000;
            cs_s   <= 2'b11;
            pico_s <= 2'b00;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            cs_s   <= {cs_s[0], cs};
            pico_s <= {pico_s[0], pico};
        end
    end

    assign cs_sync     = cs_s[1];
    assign pico_sync   = pico_s[1];
    assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

    always_ff @(posedge clock) begin
        if (reset) state <= DESELECTED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state)
            DESELECTED: begin
                if (!cs_sync) begin
                    state_next = SELECTED;
                    start      = 1'b1;
                end
            end
            SELECTED: begin
                if (cs_sync) begin
                    state_next = DESELECTED;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                end
            end
            default: state_next = DESELECTED;
        endcase
    end

    // cpha=0 reloads on the trailing edge after the 8th sample (counter already wrapped);
    // cpha=1 reloads on the 8th sample itself and skips the first leading shift of a byte.
    assign byte_done   = do_sample && (bit_cnt == 3'd7);
    assign reload      = cpha ? byte_done : (do_shift && (bit_cnt == 3'd0));
    assign tx_step     = do_shift && !reload && (!cpha || (bit_cnt != 3'd0));
    assign tx_consume  = start || reload;
    assign tx_load_val = tx_full ? tx_buf : 8'hff;
    assign rx_byte     = {rx_shift[6:0], pico_sync};
    assign busy        = (state == SELECTED) && (bit_cnt != 3'd0);

    assign poci = (state == SELECTED) ? tx_shift[7] : 1'bz;

    assign write_ok  = write_request && (|write_strobe);
    assign wr_cpol   = write_ok && (rw_address == ADDR_CPOL)   && (write_data[31:1] == 31'd0);
    assign wr_cpha   = write_ok && (rw_address == ADDR_CPHA)   && (write_data[31:1] == 31'd0);
    assign wr_txdata = write_ok && (rw_address == ADDR_TXDATA) && (write_data[31:8] == 24'd0);
    assign wr_status = write_ok && (rw_address == ADDR_STATUS) && (write_data[31:3] == 29'd0);
    assign rd_rx     = read_request && (rw_address == ADDR_RXDATA);

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'hff;
        end else begin
            if (state_next == DESELECTED) bit_cnt <= 3'd0;
            else if (do_sample)           bit_cnt <= bit_cnt + 3'd1;

            if (do_sample) rx_shift <= rx_byte;

            if (tx_consume)   tx_shift <= tx_load_val;
            else if (tx_step) tx_shift <= {tx_shift[6:0], 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            tx_buf     <= 8'hff;
            tx_full    <= 1'b0;
            rx_buf     <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr_cpol) cpol <= write_data[0];
            if (wr_cpha) cpha <= write_data[0];

            // A CPU write in the reload cycle wins: old tx_buf goes out, new one is kept.
            if (wr_txdata) begin
                tx_buf  <= write_data[7:0];
                tx_full <= 1'b1;
            end else if (tx_consume) begin
                tx_full <= 1'b0;
            end

            if (byte_done && (!rx_valid || rd_rx)) begin
                rx_buf   <= rx_byte;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end

            if (byte_done && rx_valid && !rd_rx) rx_overrun <= 1'b1;
            else if (wr_status && write_data[2]) rx_overrun <= 1'b0;
        end
    end

`ifdef RVSTEEL_SPI_PERIPHERAL_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en <= 2'b00;
            irq    <= 1'b0;
        end else begin
            if (write_ok && (rw_address == ADDR_IRQ_EN) && (write_data[31:2] == 30'd0))
                irq_en <= write_data[1:0];
            irq <= (irq_en[0] & rx_valid) | (irq_en[1] & ~tx_full);
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data      <= NO_DATA;
            read_response  <= 1'b0;
            write_response <= 1'b0;
        end else begin
            read_response  <= read_request;
            write_response <= write_request;
            read_data      <= NO_DATA;
            if (read_request) begin
                case (rw_address)
                    ADDR_CPOL:   read_data <= {31'd0, cpol};
                    ADDR_CPHA:   read_data <= {31'd0, cpha};
                    ADDR_TXDATA: read_data <= {24'd0, tx_buf};
                    ADDR_RXDATA: read_data <= {24'd0, rx_buf};
                    ADDR_STATUS: read_data <= {28'd0, busy, rx_overrun, tx_full, rx_valid};
`ifdef RVSTEEL_SPI_PERIPHERAL_IRQ_EN
                    ADDR_IRQ_EN: read_data <= {30'd0, irq_en};
`endif
                    default:     read_data <= NO_DATA;
                endcase
            end
        end
    end

endmodule
